// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Memory stage of an RV32I 5-stage pipeline. Issues loads and
//            stores on a valid/ready data-memory port with a variable-latency
//            response. Stalls the pipeline while an access is in flight,
//            formats load data and writes the MEM/WB register.
// Ports    : clk, rst (async, active-low)
//            EX/MEM in : reg_wrM, wb_selM, funct3M, instr_opcodeM, AddrM,
//                        ALUResultM, rdata2M, InstM
//            dmem      : dmem_valid/ready/we/addr/wdata/be (request),
//                        dmem_rvalid/rdata (response)
//            control   : stall
//            MEM/WB out: reg_wrW, wb_selW, AddrW, ALUResultW, rdataW, InstW,
//                        misalign, bus_err
// Options  : define LSU_TIMEOUT_EN to abort accesses that spend
//            TIMEOUT_CYCLES cycles in REQ+RESP (reported on bus_err).
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wrM,
    input  logic [1:0]  wb_selM,
    input  logic [2:0]  funct3M,
    input  logic [6:0]  instr_opcodeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] rdata2M,
    input  logic [31:0] InstM,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        reg_wrW,
    output logic [1:0]  wb_selW,
    output logic [31:0] AddrW,
    output logic [31:0] ALUResultW,
    output logic [31:0] rdataW,
    output logic [31:0] InstW,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        is_load, is_store, mem_op, size_byte, size_half, size_word;
    logic        misaligned, aligned_mem;
    logic [3:0]  be_m;
    logic [31:0] wdata_m;
    logic [1:0]  ld_off;
    logic [2:0]  ld_f3;
    logic [31:0] ld_shifted, ld_fmt, load_data;
    logic        timeout_hit;   // abort condition this cycle (no completion)
    logic        aborted;       // current access ended by timeout

    // ---------------- instruction decode (M stage) ----------------
    assign is_load    = (instr_opcodeM == OP_LOAD);
    assign is_store   = (instr_opcodeM == OP_STORE);
    assign mem_op     = is_load | is_store;
    assign size_byte  = (funct3M[1:0] == 2'b00);
    assign size_half  = (funct3M[1:0] == 2'b01);
    assign size_word  = ~size_byte & ~size_half;   // unlisted encodings act as word
    assign misaligned = mem_op & ((size_half & ALUResultM[0]) |
                                  (size_word & (|ALUResultM[1:0])));
    assign aligned_mem = mem_op & ~misaligned;

    always_comb begin
        be_m    = 4'b1111;
        wdata_m = rdata2M;
        if (size_byte) begin
            be_m    = 4'b0001 << ALUResultM[1:0];
            wdata_m = {4{rdata2M[7:0]}};
        end else if (size_half) begin
            be_m    = 4'b0011 << ALUResultM[1:0];
            wdata_m = {2{rdata2M[15:0]}};
        end
    end

    // Stall until DONE so EX/MEM (and our M inputs) stay frozen meanwhile.
    assign stall      = aligned_mem & (state != DONE);
    assign dmem_valid = (state == REQ);

    // ---------------- optional timeout ----------------
`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = (tmo_cnt == CNT_LAST) &
                         (((state == REQ)  & ~dmem_ready) |
                          ((state == RESP) & ~dmem_rvalid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            aborted <= 1'b0;
        end else begin
            if (state == IDLE && aligned_mem) begin
                tmo_cnt <= '0;
                aborted <= 1'b0;
            end else if (state == REQ || state == RESP) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (timeout_hit) aborted <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
    assign aborted     = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aligned_mem) state_nxt = REQ;
            REQ:     if (dmem_ready)       state_nxt = dmem_we ? DONE : RESP;
                     else if (timeout_hit) state_nxt = DONE;
            RESP:    if (dmem_rvalid || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- request latch and load capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            ld_off     <= '0;
            ld_f3      <= '0;
            load_data  <= '0;
        end else begin
            if (state == IDLE && aligned_mem) begin
                dmem_we    <= is_store;
                dmem_addr  <= {ALUResultM[31:2], 2'b00};
                dmem_wdata <= wdata_m;
                dmem_be    <= be_m;
                ld_off     <= ALUResultM[1:0];
                ld_f3      <= funct3M;
            end
            // A response only counts once the request has been accepted.
            if (state == RESP && dmem_rvalid) load_data <= ld_fmt;
        end
    end

    assign ld_shifted = dmem_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_f3[1:0])
            2'b00:   ld_fmt = {{24{ld_shifted[7]  & ~ld_f3[2]}}, ld_shifted[7:0]};
            2'b01:   ld_fmt = {{16{ld_shifted[15] & ~ld_f3[2]}}, ld_shifted[15:0]};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // ---------------- MEM/WB register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || stall) begin
            // reset, or bubble while the access is outstanding
            reg_wrW    <= 1'b0;
            wb_selW    <= '0;
            AddrW      <= '0;
            ALUResultW <= '0;
            rdataW     <= '0;
            InstW      <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            reg_wrW    <= reg_wrM & ~misaligned & ~((state == DONE) & aborted);
            wb_selW    <= wb_selM;
            AddrW      <= AddrM;
            ALUResultW <= ALUResultM;
            InstW      <= InstM;
            rdataW     <= (state == DONE && is_load && !aborted) ? load_data : '0;
            misalign   <= misaligned;
            bus_err    <= (state == DONE) & aborted;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Directed self-checking bench for mem_stage_lsu. Expected MEM/WB
//            captures are queued when an instruction is driven into M and
//            compared when the pipeline advances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wrM;
    logic [1:0]  wb_selM;
    logic [2:0]  funct3M;
    logic [6:0]  instr_opcodeM;
    logic [31:0] AddrM, ALUResultM, rdata2M, InstM;
    logic        dmem_valid, dmem_ready, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, reg_wrW, misalign, bus_err;
    logic [1:0]  wb_selW;
    logic [31:0] AddrW, ALUResultW, rdataW, InstW;

    mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst_n),
        .reg_wrM(reg_wrM), .wb_selM(wb_selM), .funct3M(funct3M),
        .instr_opcodeM(instr_opcodeM), .AddrM(AddrM), .ALUResultM(ALUResultM),
        .rdata2M(rdata2M), .InstM(InstM),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall(stall), .reg_wrW(reg_wrW), .wb_selW(wb_selW), .AddrW(AddrW),
        .ALUResultW(ALUResultW), .rdataW(rdataW), .InstW(InstW),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_wr;
        logic [1:0]  wb_sel;
        logic [31:0] addr, alu, rdata, inst;
        logic        mis, berr;
    } wexp_t;

    wexp_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc       = 32'h0000_0100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic rw, input logic [31:0] inst);
        instr_opcodeM = op;
        funct3M       = f3;
        ALUResultM    = alu;
        rdata2M       = rs2;
        reg_wrM       = rw;
        InstM         = inst;
        wb_selM       = (op == OP_LOAD) ? 2'b01 : 2'b00;
        AddrM         = pc;
        pc            = pc + 32'd4;
    endtask

    // expectation for the instruction currently driven in M
    task automatic push(input logic rw, input logic [31:0] rd, input logic mis, input logic berr);
        wexp_t e;
        e.reg_wr = rw;  e.wb_sel = wb_selM; e.addr = AddrM; e.alu = ALUResultM;
        e.rdata  = rd;  e.inst   = InstM;   e.mis  = mis;   e.berr = berr;
        sb.push_back(e);
    endtask

    task automatic check_w(input string tag);
        wexp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=W capture expected=none queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".reg_wrW"},    {31'd0, reg_wrW},  {31'd0, e.reg_wr});
            chk({tag, ".wb_selW"},    {30'd0, wb_selW},  {30'd0, e.wb_sel});
            chk({tag, ".AddrW"},      AddrW,             e.addr);
            chk({tag, ".ALUResultW"}, ALUResultW,        e.alu);
            chk({tag, ".rdataW"},     rdataW,            e.rdata);
            chk({tag, ".InstW"},      InstW,             e.inst);
            chk({tag, ".misalign"},   {31'd0, misalign}, {31'd0, e.mis});
            chk({tag, ".bus_err"},    {31'd0, bus_err},  {31'd0, e.berr});
        end
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, ".bubble_reg_wrW"}, {31'd0, reg_wrW}, 32'd0);
        chk({tag, ".bubble_InstW"},   InstW,            32'd0);
    endtask

    // Memory op with ready on the first REQ cycle and rvalid on the first RESP cycle.
    task automatic mem_simple(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input logic [31:0] rd_in, input logic [31:0] exp_rd,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        set_m(op, f3, alu, rs2, op == OP_LOAD, 32'h00A0_0000 | alu);
        push(op == OP_LOAD, exp_rd, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        #1;
        chk({tag, ".stall_idle"}, {31'd0, stall}, 32'd1);
        step();                                         // REQ
        chk({tag, ".valid"}, {31'd0, dmem_valid}, 32'd1);
        chk({tag, ".be"},    {28'd0, dmem_be},    {28'd0, exp_be});
        chk({tag, ".addr"},  dmem_addr,           {alu[31:2], 2'b00});
        if (op == OP_STORE) chk({tag, ".wdata"}, dmem_wdata, exp_wd);
        step();                                         // RESP (load) / DONE (store)
        dmem_ready = 1'b0;
        if (op == OP_LOAD) begin
            chk({tag, ".stall_resp"}, {31'd0, stall}, 32'd1);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd_in;
            step();                                     // DONE
            dmem_rvalid = 1'b0;
        end
        chk({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
        step();
        check_w(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        set_m(7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        #2;
        chk("rst.valid",   {31'd0, dmem_valid}, 32'd0);
        chk("rst.stall",   {31'd0, stall},      32'd0);
        chk("rst.reg_wrW", {31'd0, reg_wrW},    32'd0);
        chk("rst.AddrW",   AddrW,               32'd0);
        chk("rst.bus_err", {31'd0, bus_err},    32'd0);
        step(); step();
        rst_n = 1'b1;

        // ADD passes straight through
        set_m(OP_ALU, 3'd0, 32'h15, 32'd0, 1'b1, 32'h00B5_0533);
        push(1'b1, 32'd0, 1'b0, 1'b0);
        #1;
        chk("add.stall", {31'd0, stall},      32'd0);
        chk("add.valid", {31'd0, dmem_valid}, 32'd0);
        step();
        check_w("add");

        // SB to byte lane 3, stalls for two cycles
        set_m(OP_STORE, 3'b000, 32'h1003, 32'hAABB_CCDD, 1'b0, 32'h00B1_81A3);
        push(1'b0, 32'd0, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        #1;
        chk("sb.stall_idle", {31'd0, stall}, 32'd1);
        step();
        chk("sb.valid", {31'd0, dmem_valid}, 32'd1);
        chk("sb.we",    {31'd0, dmem_we},    32'd1);
        chk("sb.be",    {28'd0, dmem_be},    32'h8);
        chk("sb.wdata", dmem_wdata,          32'hDDDD_DDDD);
        chk("sb.addr",  dmem_addr,           32'h0000_1000);
        chk("sb.stall_req", {31'd0, stall},  32'd1);
        check_bubble("sb.req");
        step();
        dmem_ready = 1'b0;
        chk("sb.valid_done", {31'd0, dmem_valid}, 32'd0);
        chk("sb.stall_done", {31'd0, stall},      32'd0);
        check_bubble("sb.done");
        step();
        check_w("sb");

        mem_simple("sh",  OP_STORE, 3'b001, 32'h1002, 32'h1234_BEEF, 32'd0, 32'd0, 4'b1100, 32'hBEEF_BEEF);
        mem_simple("sw",  OP_STORE, 3'b010, 32'h1008, 32'hCAFE_F00D, 32'd0, 32'd0, 4'b1111, 32'hCAFE_F00D);

        // LB with ready low two cycles, response three cycles after acceptance
        set_m(OP_LOAD, 3'b000, 32'h2001, 32'd0, 1'b1, 32'h0010_8083);
        push(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        #1;
        chk("lb.stall_idle", {31'd0, stall}, 32'd1);
        step();
        chk("lb.valid_req1", {31'd0, dmem_valid}, 32'd1);
        chk("lb.be",         {28'd0, dmem_be},    32'h2);
        chk("lb.we",         {31'd0, dmem_we},    32'd0);
        step();
        chk("lb.valid_req2", {31'd0, dmem_valid}, 32'd1);
        chk("lb.addr_req2",  dmem_addr,           32'h0000_2000);
        step();
        dmem_ready  = 1'b1;
        dmem_rvalid = 1'b1;                // same-cycle response must be ignored
        dmem_rdata  = 32'h1234_5678;
        #1;
        chk("lb.stall_req3", {31'd0, stall}, 32'd1);
        step();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        chk("lb.valid_resp", {31'd0, dmem_valid}, 32'd0);
        chk("lb.stall_resp1", {31'd0, stall}, 32'd1);
        step();
        chk("lb.stall_resp2", {31'd0, stall}, 32'd1);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_8000;
        #1;
        chk("lb.stall_resp3", {31'd0, stall}, 32'd1);
        step();
        dmem_rvalid = 1'b0;
        chk("lb.stall_done", {31'd0, stall}, 32'd0);
        step();
        check_w("lb");

        mem_simple("lhu", OP_LOAD, 3'b101, 32'h2002, 32'd0, 32'h8001_0000, 32'h0000_8001, 4'b1100, 32'd0);
        mem_simple("lh",  OP_LOAD, 3'b001, 32'h2000, 32'd0, 32'h1234_8765, 32'hFFFF_8765, 4'b0011, 32'd0);
        mem_simple("lbu", OP_LOAD, 3'b100, 32'h2003, 32'd0, 32'hF100_0000, 32'h0000_00F1, 4'b1000, 32'd0);

        // misaligned LW: no request, one-cycle misalign flag
        set_m(OP_LOAD, 3'b010, 32'h2006, 32'd0, 1'b1, 32'h0060_2103);
        push(1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        chk("lwmis.stall", {31'd0, stall},      32'd0);
        chk("lwmis.valid", {31'd0, dmem_valid}, 32'd0);
        step();
        check_w("lwmis");
        set_m(7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        push(1'b0, 32'd0, 1'b0, 1'b0);
        step();
        check_w("lwmis_next");

        // reset while in REQ drops dmem_valid without a clock edge
        set_m(OP_LOAD, 3'b010, 32'h3000, 32'd0, 1'b1, 32'h0000_2183);
        step();
        chk("rstreq.valid_before", {31'd0, dmem_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstreq.valid_after", {31'd0, dmem_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rstreq.stall_idle", {31'd0, stall}, 32'd1);
        step();
        dmem_ready = 1'b1;
        step();                            // now in RESP
        dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstresp.valid", {31'd0, dmem_valid}, 32'd0);
        chk("rstresp.AddrW", AddrW,               32'd0);
        chk("rstresp.InstW", InstW,               32'd0);
        dmem_rvalid = 1'b1;                // late response, must not be consumed
        dmem_rdata  = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        push(1'b1, 32'h1122_3344, 1'b0, 1'b0);
        step();                            // IDLE -> REQ
        chk("rstresp.valid_req", {31'd0, dmem_valid}, 32'd1);
        dmem_rvalid = 1'b0;
        dmem_ready  = 1'b1;
        step();                            // RESP
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1122_3344;
        step();                            // DONE
        dmem_rvalid = 1'b0;
        chk("rstresp.stall_done", {31'd0, stall}, 32'd0);
        step();
        check_w("rstresp");

`ifdef LSU_TIMEOUT_EN
        // ready never arrives: abort after 8 REQ cycles
        set_m(OP_LOAD, 3'b010, 32'h4000, 32'd0, 1'b1, 32'h0000_2203);
        push(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tmo.valid_req", {31'd0, dmem_valid}, 32'd1);
        end
        step();
        chk("tmo.valid_done", {31'd0, dmem_valid}, 32'd0);
        chk("tmo.stall_done", {31'd0, stall},      32'd0);
        step();
        check_w("tmo");
        set_m(7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        push(1'b0, 32'd0, 1'b0, 1'b0);
        step();
        check_w("tmo_next");
`endif

        set_m(7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        step(); step();
        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage of the RV32I 5-stage pipeline. It consumes the EX/MEM register outputs and performs loads and stores on a data-memory port that uses a valid/ready request handshake and a variable-latency response.
- It stalls the pipeline while an access is in flight.
- It formats load data (byte/half/word extract, sign or zero extension) and writes the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in REQ+RESP before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
reg_wrM  in  1  register write enable of M instruction
wb_selM  in  2  writeback select of M instruction
funct3M  in  3  access size/sign
instr_opcodeM  in  7  opcode; 0000011 = load, 0100011 = store
AddrM  in  32  PC of M instruction
ALUResultM  in  32  effective address / ALU result
rdata2M  in  32  store data
InstM  in  32  instruction word
dmem_valid  out  1  request valid
dmem_ready  in  1  memory accepts request
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  store data, lane-replicated
dmem_be  out  4  byte enables
dmem_rvalid  in  1  load response valid
dmem_rdata  in  32  load response word
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
reg_wrW  out  1  MEM/WB register write enable
wb_selW  out  2  MEM/WB writeback select
AddrW, ALUResultW, rdataW, InstW  out  32 each  MEM/WB registered fields
misalign  out  1  misaligned access flag, aligned with W
bus_err  out  1  access aborted by timeout, aligned with W

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, all W outputs 0, misalign=0, bus_err=0, dmem_valid=0 immediately, including mid-transaction. No response arriving after reset is consumed.
- Memory op = opcode is load or store. Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Non-memory op or misaligned op: stall=0. MEM/WB captures the M fields next edge; rdataW=0.
  - Misaligned: reg_wrW forced 0, misalign=1 for that single W cycle. No bus request.
- FSM states:
  - IDLE: an aligned memory op latches addr/we/be/wdata and moves to REQ.
  - REQ: dmem_valid=1. When dmem_ready=1, a store goes to DONE and a load goes to RESP.
  - RESP: when dmem_rvalid=1, capture the formatted load data and go to DONE.
  - DONE: go to IDLE.
- dmem_valid is high only in REQ. Request fields stay stable while in REQ.
- stall = aligned memory op in M AND state != DONE.
  - Minimum memory-op latency is 3 cycles: IDLE, REQ with ready=1, DONE. The load minimum is 4.
  - dmem_rvalid in the same cycle as acceptance is ignored. The response must arrive after REQ.
- While stall=1, MEM/WB captures a bubble: reg_wrW=0, InstW=0, other W fields 0. In DONE the real instruction is captured and the pipeline advances.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Loads: be as for stores. The selected byte/half is shifted from the addr[1:0] lane.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW takes the word.
  - Unlisted funct3 is treated as LW/SW.
- dmem_rvalid outside RESP is ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When count reaches TIMEOUT_CYCLES-1 without completion, the FSM goes to DONE with dmem_valid dropped.
  - The W capture has reg_wrW=0, rdataW=0, bus_err=1 for one cycle.
- LSU_TIMEOUT_EN not defined: no counter. REQ/RESP wait indefinitely, and bus_err is tied to 0.

Test Plan:
- ADD passes through (opcode 0110011, ALUResultM=0x15, reg_wrM=1) -> stall=0; next cycle ALUResultW=0x15, reg_wrW=1.
- SB, addr 0x1003, rs2=0xAABBCCDD, ready=1 on first REQ cycle -> dmem_be=1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x1000; stall for 2 cycles; then W captures.
- LB addr 0x2001, rdata=0x00008000 returned 3 cycles after acceptance, ready held low 2 cycles -> stall held throughout; rdataW=0xFFFFFF80, reg_wrW=1.
- LHU addr 0x2002, rdata=0x80010000 -> rdataW=0x00008001. LW addr 0x2006 -> no dmem_valid, misalign=1, reg_wrW=0, stall=0.
- Reset asserted while in RESP -> dmem_valid=0 and all W outputs 0 asynchronously; a late rvalid after reset is ignored; the next load completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, ready held 0 -> abort after 8 cycles in REQ; bus_err=1 for one cycle, reg_wrW=0, stall released.
